alu_requester: RTL and testbench

- Initiator side of the ALU start/done operation interface: accepts operation commands from an upstream valid/ready channel, drives start/opcode/A/B toward the ALU, waits for done, captures the result and returns it on a downstream valid/ready response channel.
- Sits between the test/stimulus or control logic and the ALU.
- Provides a done-timeout watchdog and a completed-operation counter.

---
 rtl/alu_requester_if.sv | 39 +++
 rtl/alu_requester.sv | 118 +++++++++++
 tb/tb_alu_requester.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_requester_if.sv
// Handshake bundle for alu_requester: upstream command channel,
// ALU start/done channel and downstream response channel.
interface alu_requester_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_a;
  logic [DATA_W-1:0] cmd_b;

  logic              start;
  logic [2:0]        opcode;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic              done;
  logic [RES_W-1:0]  result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [RES_W-1:0]  rsp_result;
  logic [2:0]        rsp_op;
  logic              rsp_err;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b,
    input  done, result, rsp_ready,
    output cmd_ready, start, opcode, A, B,
    output rsp_valid, rsp_result, rsp_op, rsp_err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b,
    output done, result, rsp_ready,
    input  cmd_ready, start, opcode, A, B,
    input  rsp_valid, rsp_result, rsp_op, rsp_err
  );
endinterface

// File: rtl/alu_requester.sv
// ALU start/done initiator: takes commands, runs one ALU op at a time
// with a done watchdog, and returns results on a response channel.
module alu_requester #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_requester_if.master  bus,
  output logic [CNT_W-1:0] op_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    GAP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [TW-1:0]     tcnt;
  logic              cmd_fire;
  logic              rsp_fire;
  logic              t_exp;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [RES_W-1:0]  res_q;
  logic [2:0]        rop_q;
  logic              err_q;

  assign cmd_fire = bus.cmd_valid & bus.cmd_ready;
  assign rsp_fire = bus.rsp_valid & bus.rsp_ready;
  assign t_exp    = (tcnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (cmd_fire)
          state_nx = (bus.cmd_op == 3'd0) ? RESP : ISSUE;
      end
      (state == ISSUE): begin
        if (bus.done || t_exp) state_nx = RESP;
      end
      (state == RESP): begin
        if (rsp_fire) state_nx = GAP;
      end
      default: state_nx = IDLE;
    endcase
  end

  // cmd_ready is held low while reset is asserted
  always_comb begin
    bus.start     = 1'b0;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (1'b1)
      (state == IDLE):  bus.cmd_ready = reset_n;
      (state == ISSUE): bus.start     = 1'b1;
      (state == RESP):  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      rop_q    <= '0;
      err_q    <= 1'b0;
      tcnt     <= '0;
      op_count <= '0;
    end else begin
      if (cmd_fire) begin
        op_q  <= bus.cmd_op;
        a_q   <= bus.cmd_a;
        b_q   <= bus.cmd_b;
        rop_q <= bus.cmd_op;
        res_q <= '0;
        err_q <= 1'b0;
      end
      // done wins over an expiring watchdog in the same cycle
      if (state == ISSUE) begin
        tcnt <= tcnt + 1'b1;
        if (bus.done) begin
          res_q <= bus.result;
          err_q <= 1'b0;
        end else if (t_exp) begin
          err_q <= 1'b1;
        end
      end else begin
        tcnt <= '0;
      end
      if (rsp_fire) op_count <= op_count + 1'b1;
    end
  end

  assign bus.opcode     = op_q;
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_op     = rop_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_requester.sv
// Directed bench for alu_requester: behavioural ALU with programmable
// done latency, response scoreboard and start-pulse monitor.
module tb_alu_requester;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] op_count;
  logic        alu_done = 1'b0;
  logic        force_done = 1'b0;
  int          alu_lat = 1;

  int          total = 0;
  int          passed = 0;
  logic [15:0] exp_cnt = '0;
  exp_t        sb[$];

  int          hi_cnt = 0;
  int          lo_cnt = 0;
  int          last_hi = 0;
  int          last_gap = 0;
  int          rises = 0;
  logic [7:0]  a0, b0;
  logic [2:0]  o0;

  alu_requester_if bus ();

  alu_requester dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_ref(
    input logic [2:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [15:0] r;
    case (op)
      3'd1:    r = {8'h00, a} + {8'h00, b};
      3'd2:    r = {8'h00, a} - {8'h00, b};
      3'd3:    r = {8'h00, ~a};
      3'd4:    r = {8'h00, a ^ b};
      3'd5:    r = {8'h00, a & b};
      3'd6:    r = {8'h00, a} * {8'h00, b};
      3'd7:    r = {8'h00, a} + 16'd1;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign bus.done   = alu_done | force_done;
  assign bus.result = alu_ref(bus.opcode, bus.A, bus.B);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ALU model plus start-pulse monitor
  always @(posedge clk) begin
    #1;
    if (bus.start) begin
      if (hi_cnt == 0) begin
        rises++;
        last_gap = lo_cnt;
        a0 = bus.A;
        b0 = bus.B;
        o0 = bus.opcode;
      end else begin
        chk("opnd_stable", {bus.opcode, bus.A, bus.B}, {o0, a0, b0});
      end
      hi_cnt++;
      lo_cnt = 0;
    end else begin
      if (hi_cnt != 0) last_hi = hi_cnt;
      hi_cnt = 0;
      lo_cnt++;
    end
    alu_done = bus.start && (alu_lat != 0) && (hi_cnt == alu_lat);
  end

  task automatic accept(input bit keep);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      step();
      n++;
    end
    chk("cmd_accept", bus.cmd_ready, 1);
    step();
    if (!keep) bus.cmd_valid = 1'b0;
  endtask

  task automatic send(input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] res,
                      input logic err, input bit push, input bit keep);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    if (push) sb.push_back({op, res, err});
    accept(keep);
  endtask

  task automatic recv(input string tag, input int hold);
    exp_t        e;
    int          n;
    logic [15:0] r, c;
    logic [2:0]  o;
    logic        er;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      step();
      n++;
    end
    chk({tag, "_valid"}, bus.rsp_valid, 1);
    r  = bus.rsp_result;
    o  = bus.rsp_op;
    er = bus.rsp_err;
    c  = op_count;
    for (int i = 0; i < hold; i++) begin
      step();
      chk({tag, "_hold"},
          {bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err,
           bus.cmd_ready, op_count},
          {1'b1, r, o, er, 1'b0, c});
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk({tag, "_count"}, op_count, exp_cnt);
    chk({tag, "_gap"}, {bus.start, bus.cmd_ready, bus.rsp_valid}, 3'b000);
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, r, e.res);
      chk({tag, "_op"}, o, e.op);
      chk({tag, "_err"}, er, e.err);
    end
  endtask

  initial begin
    int r0;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;

    repeat (2) step();
    chk("rst_start", bus.start, 0);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_fields", {bus.rsp_result, bus.rsp_op, bus.rsp_err}, 0);
    chk("rst_alu_out", {bus.opcode, bus.A, bus.B}, 0);
    chk("rst_count", op_count, 0);
    reset_n = 1'b1;
    step();
    chk("idle_ready", bus.cmd_ready, 1);

    alu_lat = 1;
    send(3'd1, 8'h05, 8'h03, 16'h0008, 1'b0, 1, 0);
    recv("add", 0);
    chk("add_start_len", last_hi, 1);

    alu_lat = 3;
    send(3'd6, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1, 0);
    recv("mul", 0);
    chk("mul_start_len", last_hi, 3);

    alu_lat = 2;
    send(3'd4, 8'hF0, 8'h0F, 16'h00FF, 1'b0, 1, 1);
    bus.cmd_op = 3'd5;
    sb.push_back({3'd5, 16'h0000, 1'b0});
    recv("xor", 0);
    accept(0);
    recv("and", 0);
    chk("b2b_gap", last_gap, 3);

    alu_lat = 0;
    send(3'd4, 8'h12, 8'h34, 16'h0000, 1'b1, 1, 0);
    recv("tmo", 0);
    chk("tmo_start_len", last_hi, 16);

    alu_lat = 1;
    send(3'd7, 8'h7F, 8'h00, 16'h0080, 1'b0, 1, 0);
    recv("inc", 0);

    alu_lat = 2;
    send(3'd2, 8'h10, 8'h01, 16'h000F, 1'b0, 1, 0);
    recv("sub_stall", 5);

    r0 = rises;
    send(3'd0, 8'hAA, 8'hBB, 16'h0000, 1'b0, 1, 0);
    recv("nop", 0);
    chk("nop_no_start", rises, r0);

    alu_lat = 0;
    send(3'd6, 8'h12, 8'h34, 16'h0000, 1'b0, 0, 0);
    repeat (3) step();
    chk("mid_issue_start", bus.start, 1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_start_drop", bus.start, 0);
    chk("async_rsp_valid", bus.rsp_valid, 0);
    chk("async_count", op_count, 0);
    exp_cnt = '0;
    step();
    reset_n = 1'b1;
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    chk("late_done_ignored",
        {bus.start, bus.rsp_valid, bus.cmd_ready}, 3'b001);
    step();
    chk("late_done_idle", {bus.start, bus.rsp_valid}, 2'b00);

    alu_lat = 1;
    send(3'd1, 8'h05, 8'h03, 16'h0008, 1'b0, 1, 0);
    recv("post_rst", 0);
    chk("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
